// File: rtl/matrix_pkg.sv
// Shared definitions for the HUB75 display stage of the sand simulator.
// Contents: panel geometry, framebuffer sizing, the scan state enum and a
// helper that slices one BCM bit-plane out of an RGB444 pixel.
package matrix_pkg;

  localparam int PANEL_W      = 64;
  localparam int PANEL_H      = 64;
  localparam int SCAN_ROWS    = 32;
  localparam int COLOR_BITS   = 4;
  localparam int PIX_W        = 3 * COLOR_BITS;
  localparam int FB_DEPTH     = SCAN_ROWS * PANEL_W;
  localparam int FB_AW        = $clog2(FB_DEPTH);
  // Two hub_clk phases per column.
  localparam int SHIFT_CYCLES = 2 * PANEL_W;

  typedef enum logic [2:0] {
    PRIME,
    SHIFT,
    BLANK,
    LATCH,
    DISPLAY
  } scan_state_t;

  // Returns {R[plane], G[plane], B[plane]} of an RGB444 pixel.
  function automatic logic [2:0] plane_bits(input logic [11:0] px,
                                            input logic [1:0]  plane);
    return {px[{2'b10, plane}], px[{2'b01, plane}], px[{2'b00, plane}]};
  endfunction

endpackage

// File: rtl/framebuffer_bank.sv
// One half of the display framebuffer: 2048 x 12 simple dual-port RAM.
// Ports:
//   clk        - clock for both ports
//   write_en   - write strobe
//   write_addr - write address {row[4:0], col[5:0]}
//   write_data - RGB444 pixel
//   read_addr  - read address, sampled every cycle
//   read_data  - registered read data, valid one cycle after read_addr
// A read and a write to the same address in one cycle returns the old word.
// Contents are deliberately not reset.
module framebuffer_bank
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             write_en,
  input  logic [FB_AW-1:0] write_addr,
  input  logic [PIX_W-1:0] write_data,
  input  logic [FB_AW-1:0] read_addr,
  output logic [PIX_W-1:0] read_data
);

  logic [PIX_W-1:0] mem [0:FB_DEPTH-1];

  // Non-blocking update of both mem and read_data gives read-before-write.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
    read_data <= mem[read_addr];
  end

endmodule

// File: rtl/hub75_matrix_driver.sv
// HUB75 driver for a 64x64, 1/32-scan LED panel with 4-bit BCM per channel.
// Accepts pixel writes into a double-banked framebuffer (bank = write_y[5])
// and continuously scans it out row-pair by row-pair, bit-plane by bit-plane.
// Ports:
//   clk, resetn           - clock, asynchronous active-low reset
//   write_en/x/y          - pixel write strobe and coordinates (no backpressure)
//   pixel_color           - RGB444 pixel, [11:8]=R [7:4]=G [3:0]=B
//   hub_r1/g1/b1          - colour bits for rows 0..31 (bank 0)
//   hub_r2/g2/b2          - colour bits for rows 32..63 (bank 1)
//   hub_addr              - row-pair select, updated in LATCH
//   hub_clk, hub_lat      - panel shift clock and latch
//   hub_oe_n              - panel output enable, low only in DISPLAY
//   frame_sync            - one-cycle pulse on PRIME of row 0, plane 0
// Every output is a register loaded from the state the FSM is in, so the
// panel pins show each FSM cycle one clock later; all relative timing of
// the pins matches the FSM exactly.
module hub75_matrix_driver
  import matrix_pkg::*;
#(
  parameter int BASE_ON_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        write_en,
  input  logic [5:0]  write_x,
  input  logic [5:0]  write_y,
  input  logic [11:0] pixel_color,
  output logic        hub_r1,
  output logic        hub_g1,
  output logic        hub_b1,
  output logic        hub_r2,
  output logic        hub_g2,
  output logic        hub_b2,
  output logic [4:0]  hub_addr,
  output logic        hub_clk,
  output logic        hub_lat,
  output logic        hub_oe_n,
  output logic        frame_sync
);

  // One counter serves both SHIFT (0..127) and DISPLAY (0..BASE<<3 - 1).
  localparam int DISP_W = $clog2(BASE_ON_CYCLES * 8);
  localparam int CNT_W  = (DISP_W > 7) ? DISP_W : 7;

  scan_state_t      state_q, state_d;
  logic [4:0]       row_q, row_d;
  logic [1:0]       plane_q, plane_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] disp_last;

  logic [FB_AW-1:0] wr_addr, rd_addr;
  logic             wr_upper, wr_lower;
  logic [5:0]       rd_col;
  logic [PIX_W-1:0] rd_upper, rd_lower;

  logic [2:0]       upper_d, lower_d;
  logic [4:0]       addr_d;
  logic             hclk_d, lat_d, oe_n_d, fs_d;

  // ---------------------------------------------------------------------
  // Framebuffer
  // ---------------------------------------------------------------------
  assign wr_addr  = {write_y[4:0], write_x};
  assign wr_upper = write_en & ~write_y[5];
  assign wr_lower = write_en &  write_y[5];

  // PRIME fetches column 0; on each odd SHIFT step (hub_clk high) the next
  // column is fetched so it is ready for the following even step. The
  // fetch on the very last step wraps to column 0 and is simply unused.
  always_comb begin
    rd_col = 6'd0;
    if (state_q == SHIFT) begin
      rd_col = cnt_q[6:1] + 6'd1;
    end
  end

  assign rd_addr = {row_q, rd_col};

  framebuffer_bank u_bank_upper (
    .clk        (clk),
    .write_en   (wr_upper),
    .write_addr (wr_addr),
    .write_data (pixel_color),
    .read_addr  (rd_addr),
    .read_data  (rd_upper)
  );

  framebuffer_bank u_bank_lower (
    .clk        (clk),
    .write_en   (wr_lower),
    .write_addr (wr_addr),
    .write_data (pixel_color),
    .read_addr  (rd_addr),
    .read_data  (rd_lower)
  );

  // ---------------------------------------------------------------------
  // Scan FSM: next state and next output values
  // ---------------------------------------------------------------------
  assign disp_last = (CNT_W'(BASE_ON_CYCLES) << plane_q) - CNT_W'(1);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    plane_d = plane_q;
    cnt_d   = cnt_q;
    upper_d = {hub_r1, hub_g1, hub_b1};
    lower_d = {hub_r2, hub_g2, hub_b2};
    addr_d  = hub_addr;
    hclk_d  = 1'b0;
    lat_d   = 1'b0;
    oe_n_d  = 1'b1;
    fs_d    = 1'b0;

    unique case (state_q)
      PRIME: begin
        fs_d    = (row_q == 5'd0) && (plane_q == 2'd0);
        state_d = SHIFT;
        cnt_d   = '0;
      end
      SHIFT: begin
        // Even step: present the column fetched last cycle, clock low.
        // Odd step: clock high with data held.
        hclk_d = cnt_q[0];
        if (!cnt_q[0]) begin
          upper_d = plane_bits(rd_upper, plane_q);
          lower_d = plane_bits(rd_lower, plane_q);
        end
        if (cnt_q == CNT_W'(SHIFT_CYCLES - 1)) begin
          state_d = BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BLANK: begin
        state_d = LATCH;
      end
      LATCH: begin
        lat_d   = 1'b1;
        addr_d  = row_q;
        state_d = DISPLAY;
        cnt_d   = '0;
      end
      DISPLAY: begin
        oe_n_d = 1'b0;
        if (cnt_q == disp_last) begin
          state_d = PRIME;
          cnt_d   = '0;
          if (plane_q == 2'd3) begin
            plane_d = 2'd0;
            row_d   = row_q + 5'd1;
          end else begin
            plane_d = plane_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = PRIME;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= PRIME;
      row_q      <= 5'd0;
      plane_q    <= 2'd0;
      cnt_q      <= '0;
      hub_r1     <= 1'b0;
      hub_g1     <= 1'b0;
      hub_b1     <= 1'b0;
      hub_r2     <= 1'b0;
      hub_g2     <= 1'b0;
      hub_b2     <= 1'b0;
      hub_addr   <= 5'd0;
      hub_clk    <= 1'b0;
      hub_lat    <= 1'b0;
      hub_oe_n   <= 1'b1;
      frame_sync <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      plane_q    <= plane_d;
      cnt_q      <= cnt_d;
      {hub_r1, hub_g1, hub_b1} <= upper_d;
      {hub_r2, hub_g2, hub_b2} <= lower_d;
      hub_addr   <= addr_d;
      hub_clk    <= hclk_d;
      hub_lat    <= lat_d;
      hub_oe_n   <= oe_n_d;
      frame_sync <= fs_d;
    end
  end

endmodule
